// File: rtl/ecc_page_packer.sv
// Halfword-to-page packer in front of the ECC encoder: gathers up to eight
// 16-bit halfwords per page, pads short pages, and double-buffers against backpressure.
module ecc_page_packer #(
    parameter logic [15:0] PAD_VALUE = 16'h0000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [15:0]  in_data,
    input  logic         in_last,
    output logic         page_valid,
    input  logic         page_ready,
    output logic [127:0] page_data,
    output logic [3:0]   page_len,
    output logic         page_padded,
    output logic [15:0]  page_count
);

    typedef enum logic {FILL, HOLD} state_t;

    state_t             state, state_nxt;
    logic [7:0][15:0]   fill_buf_p0;
    logic [2:0]         idx_p0;
    logic [3:0]         held_len_p0;

    logic [127:0]       page_data_p1;
    logic [3:0]         page_len_p1;
    logic               page_padded_p1;
    logic               vld_p1;
    logic [15:0]        page_cnt_p1;

    logic               in_hs, out_hs, or_free, complete;
    logic               load_fill, load_hold;
    logic [127:0]       page_asm;
    logic [3:0]         cur_len;

    // Slots below the write index come from the buffer, the write index takes
    // the incoming halfword, everything above it is padding.
    function automatic logic [127:0] pad_page(input logic [7:0][15:0] slots,
                                              input logic [2:0]        wr_idx,
                                              input logic [15:0]       wr_data);
        logic [127:0] p;
        p = '0;
        for (int s = 0; s < 8; s++) begin
            if (s < int'(wr_idx))
                p[16*s +: 16] = slots[s];
            else if (s == int'(wr_idx))
                p[16*s +: 16] = wr_data;
            else
                p[16*s +: 16] = PAD_VALUE;
        end
        return p;
    endfunction

    assign in_hs     = in_valid && in_ready;
    assign out_hs    = vld_p1 && page_ready;
    assign or_free   = !vld_p1 || page_ready;
    assign complete  = in_hs && ((idx_p0 == 3'd7) || in_last);
    assign load_fill = (state == FILL) && complete && or_free;
    assign load_hold = (state == HOLD) && or_free;
    assign page_asm  = pad_page(fill_buf_p0, idx_p0, in_data);
    assign cur_len   = {1'b0, idx_p0} + 4'd1;

    always_ff @(posedge clk) begin
        if (rst)
            state <= FILL;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FILL: if (complete && !or_free) state_nxt = HOLD;
            HOLD: if (or_free)              state_nxt = FILL;
            default:                        state_nxt = FILL;
        endcase
    end

    always_comb begin
        in_ready = (state == FILL);
    end

    // Stage p0: fill buffer; a page that cannot move on is frozen here already padded
    always_ff @(posedge clk) begin
        if (rst) begin
            fill_buf_p0 <= '0;
            idx_p0      <= '0;
            held_len_p0 <= '0;
        end else if (load_hold) begin
            idx_p0 <= '0;
        end else if (in_hs) begin
            if (complete) begin
                idx_p0 <= '0;
                if (!or_free) begin
                    fill_buf_p0 <= page_asm;
                    held_len_p0 <= cur_len;
                end
            end else begin
                fill_buf_p0[idx_p0] <= in_data;
                idx_p0              <= idx_p0 + 3'd1;
            end
        end
    end

    // Stage p1: output register handed to the ECC encoder
    always_ff @(posedge clk) begin
        if (rst) begin
            page_data_p1   <= '0;
            page_len_p1    <= '0;
            page_padded_p1 <= 1'b0;
            vld_p1         <= 1'b0;
        end else if (load_fill) begin
            page_data_p1   <= page_asm;
            page_len_p1    <= cur_len;
            page_padded_p1 <= (idx_p0 != 3'd7);
            vld_p1         <= 1'b1;
        end else if (load_hold) begin
            page_data_p1   <= fill_buf_p0;
            page_len_p1    <= held_len_p0;
            page_padded_p1 <= (held_len_p0 != 4'd8);
            vld_p1         <= 1'b1;
        end else if (out_hs) begin
            vld_p1 <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            page_cnt_p1 <= '0;
        else if (out_hs)
            page_cnt_p1 <= page_cnt_p1 + 16'd1;
    end

    assign page_valid  = vld_p1;
    assign page_data   = page_data_p1;
    assign page_len    = page_len_p1;
    assign page_padded = page_padded_p1;
    assign page_count  = page_cnt_p1;

endmodule

// File: tb/tb_ecc_page_packer.sv
// Directed bench for ecc_page_packer: reset, full/short pages, backpressure,
// streaming, mid-page reset and page counter wrap.
module tb_ecc_page_packer;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [15:0]  in_data;
    logic         in_last;
    logic         page_valid;
    logic         page_ready;
    logic [127:0] page_data;
    logic [3:0]   page_len;
    logic         page_padded;
    logic [15:0]  page_count;

    int total = 0;
    int bad   = 0;

    ecc_page_packer #(.PAD_VALUE(16'h0000)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .page_valid (page_valid),
        .page_ready (page_ready),
        .page_data  (page_data),
        .page_len   (page_len),
        .page_padded(page_padded),
        .page_count (page_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // Expected full page with consecutive halfwords base, base+1, ... base+7
    function automatic logic [127:0] seq_page(input logic [15:0] base);
        logic [127:0] p;
        for (int s = 0; s < 8; s++)
            p[16*s +: 16] = base + 16'(s);
        return p;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; page_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (page_valid !== 1'b0)    begin bad++; $display("FAIL reset_valid got=%b want=0", page_valid); end
        total++; if (page_data !== 128'h0)   begin bad++; $display("FAIL reset_data got=%h want=0", page_data); end
        total++; if (page_len !== 4'd0)      begin bad++; $display("FAIL reset_len got=%0d want=0", page_len); end
        total++; if (page_padded !== 1'b0)   begin bad++; $display("FAIL reset_padded got=%b want=0", page_padded); end
        total++; if (page_count !== 16'h0)   begin bad++; $display("FAIL reset_count got=%h want=0", page_count); end
        total++; if (in_ready !== 1'b1)      begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    endtask

    task automatic test_full_page();
        page_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_data = 16'h1000 + 16'(i); in_last = 1'b0;
            tick();
        end
        in_valid = 1'b0;
        total++; if (page_valid !== 1'b1) begin bad++; $display("FAIL full_valid got=%b want=1", page_valid); end
        total++; if (page_data !== 128'h1007_1006_1005_1004_1003_1002_1001_1000)
            begin bad++; $display("FAIL full_data got=%h want=%h", page_data, 128'h1007_1006_1005_1004_1003_1002_1001_1000); end
        total++; if (page_len !== 4'd8)     begin bad++; $display("FAIL full_len got=%0d want=8", page_len); end
        total++; if (page_padded !== 1'b0)  begin bad++; $display("FAIL full_padded got=%b want=0", page_padded); end
        tick();
        total++; if (page_count !== 16'd1)  begin bad++; $display("FAIL full_count got=%0d want=1", page_count); end
        total++; if (page_valid !== 1'b0)   begin bad++; $display("FAIL full_drop got=%b want=0", page_valid); end
    endtask

    task automatic test_short_page();
        page_ready = 1'b1;
        in_valid = 1'b1; in_data = 16'hAAAA; in_last = 1'b0; tick();
        in_data = 16'hBBBB; in_last = 1'b1; tick();
        in_valid = 1'b0; in_last = 1'b0; in_data = 16'h5555;
        total++; if (page_data !== {96'h0, 32'hBBBB_AAAA})
            begin bad++; $display("FAIL short_data got=%h want=%h", page_data, {96'h0, 32'hBBBB_AAAA}); end
        total++; if (page_len !== 4'd2)    begin bad++; $display("FAIL short_len got=%0d want=2", page_len); end
        total++; if (page_padded !== 1'b1) begin bad++; $display("FAIL short_padded got=%b want=1", page_padded); end
        tick();
        total++; if (page_count !== 16'd2) begin bad++; $display("FAIL short_count got=%0d want=2", page_count); end
    endtask

    task automatic test_last_at_7();
        page_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_data = 16'h6000 + 16'(i); in_last = (i == 7);
            tick();
        end
        in_valid = 1'b0; in_last = 1'b0;
        total++; if (page_data !== seq_page(16'h6000))
            begin bad++; $display("FAIL last7_data got=%h want=%h", page_data, seq_page(16'h6000)); end
        total++; if (page_len !== 4'd8 || page_padded !== 1'b0)
            begin bad++; $display("FAIL last7_len got=%0d/%b want=8/0", page_len, page_padded); end
        tick();
        total++; if (page_count !== 16'd3) begin bad++; $display("FAIL last7_count got=%0d want=3", page_count); end
    endtask

    task automatic test_backpressure();
        logic        ready_ok;
        logic [15:0] c0;
        c0 = page_count;
        ready_ok = 1'b1;
        page_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (in_ready !== 1'b1) ready_ok = 1'b0;
            in_valid = 1'b1; in_data = 16'h2000 + 16'(i); in_last = 1'b0;
            tick();
        end
        total++; if (ready_ok !== 1'b1) begin bad++; $display("FAIL bp_fill_ready got=0 want=1"); end
        in_data = 16'hDEAD; in_last = 1'b1;
        total++; if (in_ready !== 1'b0)   begin bad++; $display("FAIL bp_hold_ready got=%b want=0", in_ready); end
        total++; if (page_valid !== 1'b1) begin bad++; $display("FAIL bp_valid got=%b want=1", page_valid); end
        tick(); tick(); tick();
        total++; if (page_data !== seq_page(16'h2000))
            begin bad++; $display("FAIL bp_stable got=%h want=%h", page_data, seq_page(16'h2000)); end
        total++; if (in_ready !== 1'b0 || page_count !== c0)
            begin bad++; $display("FAIL bp_still_hold got=%b/%0d want=0/%0d", in_ready, page_count, c0); end
        in_valid = 1'b0; in_last = 1'b0; page_ready = 1'b1;
        tick();
        page_ready = 1'b0;
        total++; if (page_data !== seq_page(16'h2008))
            begin bad++; $display("FAIL bp_second got=%h want=%h", page_data, seq_page(16'h2008)); end
        total++; if (page_valid !== 1'b1 || in_ready !== 1'b1)
            begin bad++; $display("FAIL bp_release got=%b/%b want=1/1", page_valid, in_ready); end
        total++; if (page_count !== c0 + 16'd1)
            begin bad++; $display("FAIL bp_count1 got=%0d want=%0d", page_count, c0 + 16'd1); end
        tick();
        total++; if (page_data !== seq_page(16'h2008) || page_count !== c0 + 16'd1)
            begin bad++; $display("FAIL bp_second_stable got=%h/%0d", page_data, page_count); end
        page_ready = 1'b1;
        tick();
        total++; if (page_valid !== 1'b0 || page_count !== c0 + 16'd2)
            begin bad++; $display("FAIL bp_drain got=%b/%0d want=0/%0d", page_valid, page_count, c0 + 16'd2); end
    endtask

    task automatic test_reset_mid_page();
        page_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_data = 16'h4000 + 16'(i); in_last = 1'b0;
            tick();
        end
        in_valid = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (page_valid !== 1'b0 || page_count !== 16'd0)
            begin bad++; $display("FAIL rmid_clear got=%b/%0d want=0/0", page_valid, page_count); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rmid_ready got=%b want=1", in_ready); end
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_data = 16'h5000 + 16'(i);
            tick();
            if (i < 7) begin
                total++; if (page_valid !== 1'b0) begin bad++; $display("FAIL rmid_early_page at=%0d got=1 want=0", i); end
            end
        end
        in_valid = 1'b0;
        total++; if (page_data !== seq_page(16'h5000) || page_len !== 4'd8)
            begin bad++; $display("FAIL rmid_data got=%h/%0d want=%h/8", page_data, page_len, seq_page(16'h5000)); end
        tick();
        total++; if (page_count !== 16'd1) begin bad++; $display("FAIL rmid_count got=%0d want=1", page_count); end
    endtask

    task automatic test_streaming();
        int          seen;
        logic        ready_ok;
        do_reset();
        page_ready = 1'b1;
        seen = 0;
        ready_ok = 1'b1;
        for (int i = 0; i < 64; i++) begin
            if (in_ready !== 1'b1) ready_ok = 1'b0;
            in_valid = 1'b1; in_data = 16'h3000 + 16'(i); in_last = 1'b0;
            tick();
            if (page_valid === 1'b1) begin
                total++; if (page_data !== seq_page(16'h3000 + 16'(8*seen)))
                    begin bad++; $display("FAIL stream_page%0d got=%h want=%h", seen, page_data, seq_page(16'h3000 + 16'(8*seen))); end
                seen++;
            end
        end
        in_valid = 1'b0;
        tick();
        total++; if (ready_ok !== 1'b1) begin bad++; $display("FAIL stream_ready got=0 want=1"); end
        total++; if (seen != 8) begin bad++; $display("FAIL stream_pages got=%0d want=8", seen); end
        total++; if (page_count !== 16'd8) begin bad++; $display("FAIL stream_count got=%0d want=8", page_count); end
    endtask

    task automatic test_wrap();
        do_reset();
        page_ready = 1'b1;
        for (int i = 0; i < 65536; i++) begin
            in_valid = 1'b1; in_data = 16'(i); in_last = 1'b1;
            tick();
        end
        in_valid = 1'b0; in_last = 1'b0;
        total++; if (page_count !== 16'hFFFF) begin bad++; $display("FAIL wrap_pre got=%h want=ffff", page_count); end
        total++; if (page_data !== {112'h0, 16'hFFFF} || page_len !== 4'd1 || page_padded !== 1'b1)
            begin bad++; $display("FAIL wrap_last_page got=%h/%0d/%b want=ffff/1/1", page_data, page_len, page_padded); end
        tick();
        total++; if (page_count !== 16'h0000) begin bad++; $display("FAIL wrap_count got=%h want=0000", page_count); end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; page_ready = 1'b0;
        test_reset();
        test_full_page();
        test_short_page();
        test_last_at_7();
        test_backpressure();
        test_reset_mid_page();
        test_streaming();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ecc_page_packer.md
ECC_PAGE_PACKER -- requirements
Module: ecc_page_packer

Interface
REQ-001 Parameter: PAD_VALUE, 16'h0000, halfword value written into unfilled slots of a short page.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in_valid  input  1  upstream halfword valid.
REQ-005 in_ready  output  1  packer accepts a halfword this cycle.
REQ-006 in_data  input  16  halfword payload.
REQ-007 in_last  input  1  halfword closes the current page.
REQ-008 page_valid  output  1  assembled page available to the ECC encoder stage.
REQ-009 page_ready  input  1  downstream consumes the page this cycle.
REQ-010 page_data  output  128  halfword x of the page at bits [16x+15:16x], x = 0..7.
REQ-011 page_len  output  4  count of real halfwords in page_data, 1..8.
REQ-012 page_padded  output  1  page_len < 8.
REQ-013 page_count  output  16  pages handed off downstream, wrapping.

Function
REQ-014 Input handshake = in_valid && in_ready; output handshake = page_valid && page_ready.
REQ-015 Fill buffer of eight 16-bit slots plus 3-bit write index idx; accepted halfword written to slot idx, idx increments.
REQ-016 Page completes on the halfword accepted at idx 7 or with in_last=1, whichever first; in_last at idx 7 is an ordinary full page (page_padded=0).
REQ-017 On completion, slots idx+1..7 of the page take PAD_VALUE; page_len = idx+1 of the completing halfword.
REQ-018 Output register OR (page_data, page_len, page_padded, page_valid) is free in a cycle when page_valid=0 or an output handshake occurs that cycle.
REQ-019 State machine FILL/HOLD; in_ready = 1 in FILL, 0 in HOLD.
REQ-020 FILL, completing halfword accepted, OR free: page (including that halfword) loads OR at the same edge, page_valid=1 next cycle, idx returns to 0, stay FILL; latency = 1 cycle from completing handshake to page_valid.
REQ-021 FILL, completing halfword accepted, OR not free: page retained in fill buffer, go to HOLD.
REQ-022 HOLD: when OR becomes free, held page loads OR at that edge, idx=0, go to FILL; in_ready=1 the following cycle.
REQ-023 Back-to-back: page_valid stays 1 across an output handshake if a new page loads OR at the same edge.
REQ-024 OR contents stable while page_valid=1 and page_ready=0.
REQ-025 page_valid drops to 0 after an output handshake with no new page loading.
REQ-026 page_count increments by 1 on each output handshake; 16'hFFFF wraps to 16'h0000.
REQ-027 in_data/in_last ignored when no input handshake; page_ready ignored when page_valid=0.
REQ-028 Throughput: one halfword per cycle sustained with page_ready held 1.

Reset
REQ-029 rst=1 at a rising edge: state=FILL, idx=0, fill buffer cleared to 0, page_valid=0, page_data=0, page_len=0, page_padded=0, page_count=0.
REQ-030 rst dominates all same-cycle handshakes; a partially filled or held page is discarded, not emitted.
REQ-031 in_ready=1 in the first cycle after rst deasserts.

Verification
REQ-032 Full page: in_data 16'h1000..16'h1007 on 8 consecutive cycles, page_ready=1 -> one cycle after 8th handshake page_valid=1, page_data=128'h1007_1006_1005_1004_1003_1002_1001_1000, page_len=8, page_padded=0, page_count=1 after the handshake.
REQ-033 Short page: 16'hAAAA, 16'hBBBB (in_last=1), PAD_VALUE=16'h0000 -> page_data[31:0]=32'hBBBB_AAAA, bits [127:32]=0, page_len=2, page_padded=1.
REQ-034 Backpressure: page_ready=0, send two full pages -> first page holds stable in OR, second completes, in_ready=0 (HOLD); raise page_ready one cycle -> second page appears next cycle, in_ready=1 again, no data lost or duplicated.
REQ-035 Streaming: 64 halfwords continuously, page_ready=1 -> in_ready never deasserts, 8 pages emitted in order, page_count=8.
REQ-036 Reset mid-page: accept 5 halfwords, assert rst one cycle -> no page_valid, next 8 halfwords form a page with slot 0 = first post-reset halfword.
REQ-037 Wrap: preload by streaming 65536 single-halfword in_last pages -> page_count returns to 16'h0000.
